// File: rtl/dcache_2way.sv
// Two-way set-associative, write-back, write-allocate data cache with per-set LRU
// replacement and saturating hit/miss counters.
module dcache_2way #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INDEX_W = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [7:0]        cpu_writeData,
  output logic [7:0]        cpu_readData,
  output logic              busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_address,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_busywait,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned Sets = 2 ** INDEX_W;
  localparam int unsigned TagW = ADDR_W - INDEX_W - 2;

  typedef enum logic [1:0] {StIdle, StWriteback, StFetch, StUpdate} state_e;

  state_e            state_q, state_d;
  logic [31:0]       data_q  [2][Sets];
  logic [TagW-1:0]   tag_q   [2][Sets];
  logic [1:0]        valid_q [Sets];
  logic [1:0]        dirty_q [Sets];
  logic [Sets-1:0]   lru_q;
  logic              victim_q;
  logic [TagW-1:0]   victim_tag_q;
  logic [31:0]       fill_q;
  logic              from_update_q;

  logic [TagW-1:0]    tag;
  logic [INDEX_W-1:0] idx;
  logic [1:0]         off;
  logic               access, hit, hit_sel, victim;
  logic [1:0]         hit_way;
  logic [31:0]        hit_data;
  logic               hit_commit, miss_start;

  assign tag    = address[ADDR_W-1:INDEX_W+2];
  assign idx    = address[INDEX_W+1:2];
  assign off    = address[1:0];
  assign access = read ^ write;

  assign hit_way[0] = valid_q[idx][0] && (tag_q[0][idx] == tag);
  assign hit_way[1] = valid_q[idx][1] && (tag_q[1][idx] == tag);
  assign hit        = |hit_way;
  assign hit_sel    = hit_way[1];

  // Fill invalid ways first (way 0 preferred) before consulting LRU.
  assign victim = !valid_q[idx][0] ? 1'b0 :
                  !valid_q[idx][1] ? 1'b1 : lru_q[idx];

  assign hit_data     = data_q[hit_sel][idx];
  assign cpu_readData = hit_data[{off, 3'b000} +: 8];

  assign hit_commit = (state_q == StIdle) && access && hit;
  assign miss_start = (state_q == StIdle) && access && !hit;

  assign mem_writedata = data_q[victim_q][idx];
  // Gated by reset so the stall drops immediately even with a request still held.
  assign busywait = !reset && ((state_q != StIdle) || (access && !hit));

  always_comb begin
    state_d     = state_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = {tag, idx};
    unique case (state_q)
      StIdle: begin
        if (miss_start) state_d = dirty_q[idx][victim] ? StWriteback : StFetch;
      end
      StWriteback: begin
        mem_write   = 1'b1;
        mem_address = {victim_tag_q, idx};
        if (!mem_busywait) state_d = StFetch;
      end
      StFetch: begin
        mem_read = 1'b1;
        if (!mem_busywait) state_d = StUpdate;
      end
      StUpdate: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      lru_q         <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      from_update_q <= 1'b0;
      for (int s = 0; s < Sets; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state_q       <= state_d;
      from_update_q <= (state_q == StUpdate);
      if (hit_commit) begin
        lru_q[idx] <= ~hit_sel;
        if (write) dirty_q[idx][hit_sel] <= 1'b1;
        // The completing access after a refill is not a first-try hit.
        if (!from_update_q && (hit_count != '1)) hit_count <= hit_count + CNT_W'(1);
      end
      if (miss_start && (miss_count != '1)) miss_count <= miss_count + CNT_W'(1);
      if ((state_q == StWriteback) && !mem_busywait) dirty_q[idx][victim_q] <= 1'b0;
      if (state_q == StUpdate) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (miss_start) begin
      victim_q     <= victim;
      victim_tag_q <= tag_q[victim][idx];
    end
    if ((state_q == StFetch) && !mem_busywait) fill_q <= mem_readdata;
    if (state_q == StUpdate) begin
      data_q[victim_q][idx] <= fill_q;
      tag_q[victim_q][idx]  <= tag;
    end
    if (hit_commit && write) data_q[hit_sel][idx][{off, 3'b000} +: 8] <= cpu_writeData;
  end

endmodule

// File: tb/tb_dcache_2way.sv
// Directed bench for dcache_2way: a word memory with configurable latency, a log of
// completed memory transactions, and hand-computed expectations.
module tb_dcache_2way;

  logic        clock, reset, read, write;
  logic [7:0]  address, cpu_writeData, cpu_readData, cpu_readData2;
  logic        busywait, mem_read, mem_write, busywait2, mem_read2, mem_write2;
  logic [5:0]  mem_address, mem_address2;
  logic [31:0] mem_writedata, mem_writedata2, mem_readdata;
  logic        mem_busywait;
  logic [15:0] hit_count, miss_count;
  logic [1:0]  hit_count2, miss_count2;

  int n_checks = 0;
  int n_errors = 0;

  dcache_2way #(.ADDR_W(8), .INDEX_W(2), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .read(read), .write(write), .address(address),
    .cpu_writeData(cpu_writeData), .cpu_readData(cpu_readData), .busywait(busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait), .hit_count(hit_count), .miss_count(miss_count)
  );

  // Identical stimulus with 2-bit counters to exercise saturation.
  dcache_2way #(.ADDR_W(8), .INDEX_W(2), .CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .read(read), .write(write), .address(address),
    .cpu_writeData(cpu_writeData), .cpu_readData(cpu_readData2), .busywait(busywait2),
    .mem_read(mem_read2), .mem_write(mem_write2), .mem_address(mem_address2),
    .mem_writedata(mem_writedata2), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait), .hit_count(hit_count2), .miss_count(miss_count2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory model: a request completes when it has been held for mem_lat cycles.
  logic [31:0] mem [64];
  int          mem_lat = 2;
  int          cnt = 0;
  int          n_log = 0;
  int          n_overlap = 0;
  logic        log_wr   [16];
  logic [5:0]  log_addr [16];
  logic [31:0] log_data [16];

  assign mem_busywait = !((mem_read || mem_write) && (cnt == mem_lat));
  assign mem_readdata = mem[mem_address];

  always @(posedge clock) begin
    if (mem_read && mem_write) n_overlap = n_overlap + 1;
    if (mem_read || mem_write) begin
      if (cnt == mem_lat) begin
        if (mem_write) mem[mem_address] = mem_writedata;
        if (n_log < 16) begin
          log_wr[n_log]   = mem_write;
          log_addr[n_log] = mem_address;
          log_data[n_log] = mem_writedata;
        end
        n_log = n_log + 1;
        cnt <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, output logic [7:0] rdata, output int stalls);
    @(negedge clock);
    read = rd; write = wr; address = a; cpu_writeData = wd;
    stalls = 0;
    #1;
    while (busywait && stalls < 200) begin
      @(negedge clock);
      #1;
      stalls++;
    end
    check_eq("busywait_release", {31'b0, busywait}, 32'h0);
    rdata = cpu_readData;
    @(posedge clock);
    #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic log_check(input string tag, input int i, input logic wr,
                           input logic [5:0] a, input logic [31:0] d, input logic chk_d);
    check_eq({tag, "_kind"}, {31'b0, log_wr[i]}, {31'b0, wr});
    check_eq({tag, "_addr"}, {26'b0, log_addr[i]}, {26'b0, a});
    if (chk_d) check_eq({tag, "_data"}, log_data[i], d);
  endtask

  logic [7:0] rd;
  int         st;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {8'hF0, 8'(i), 8'hE0, 8'(i)};
    mem[0] = 32'hDDCCBBAA;
    mem[4] = 32'h44332211;
    mem[8] = 32'h88776655;
    read = 0; write = 0; address = 0; cpu_writeData = 0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_eq("rst_busywait", {31'b0, busywait}, 0);
    check_eq("rst_mem_read", {31'b0, mem_read}, 0);
    check_eq("rst_mem_write", {31'b0, mem_write}, 0);
    check_eq("rst_hits", {16'b0, hit_count}, 0);
    check_eq("rst_misses", {16'b0, miss_count}, 0);
    reset = 1'b0;

    // Cold load: clean refill, then a hit in the same block.
    access(1, 0, 8'h00, 8'h00, rd, st);
    check_eq("miss0_data", {24'b0, rd}, 32'hAA);
    check_eq("miss0_stalls", st, 5);
    check_eq("miss0_misses", {16'b0, miss_count}, 1);
    check_eq("miss0_hits", {16'b0, hit_count}, 0);
    check_eq("miss0_nlog", n_log, 1);
    log_check("miss0_log", 0, 1'b0, 6'h00, 32'h0, 1'b0);
    access(1, 0, 8'h03, 8'h00, rd, st);
    check_eq("hit03_data", {24'b0, rd}, 32'hDD);
    check_eq("hit03_stalls", st, 0);
    check_eq("hit03_hits", {16'b0, hit_count}, 1);

    // Store hit then load back; no memory traffic.
    access(0, 1, 8'h01, 8'h5A, rd, st);
    check_eq("st01_stalls", st, 0);
    access(1, 0, 8'h01, 8'h00, rd, st);
    check_eq("ld01_data", {24'b0, rd}, 32'h5A);
    check_eq("st_hits", {16'b0, hit_count}, 3);
    check_eq("st_nlog", n_log, 1);

    // Fill way 1 with 0x10; way 0 (dirty 0x00) becomes LRU.
    access(1, 0, 8'h10, 8'h00, rd, st);
    check_eq("miss10_data", {24'b0, rd}, 32'h11);
    check_eq("miss10_stalls", st, 5);
    log_check("miss10_log", 1, 1'b0, 6'h04, 32'h0, 1'b0);

    // Dirty eviction of 0x00, refill of 0x20 into way 0.
    access(1, 0, 8'h20, 8'h00, rd, st);
    check_eq("miss20_data", {24'b0, rd}, 32'h55);
    check_eq("miss20_stalls", st, 8);
    check_eq("miss20_misses", {16'b0, miss_count}, 3);
    check_eq("miss20_nlog", n_log, 4);
    log_check("wb00_log", 2, 1'b1, 6'h00, 32'hDDCC5AAA, 1'b1);
    log_check("fetch20_log", 3, 1'b0, 6'h08, 32'h0, 1'b0);
    access(1, 0, 8'h10, 8'h00, rd, st);
    check_eq("hit10_stalls", st, 0);
    check_eq("hit10_data", {24'b0, rd}, 32'h11);
    check_eq("hit10_hits", {16'b0, hit_count}, 4);

    // Mixed: 0x00 replaces 0x20 (LRU), then 0x20 replaces clean 0x10.
    access(1, 0, 8'h01, 8'h00, rd, st);
    check_eq("refetch01_data", {24'b0, rd}, 32'h5A);
    check_eq("refetch01_stalls", st, 5);
    access(1, 0, 8'h10, 8'h00, rd, st);
    check_eq("mix10_stalls", st, 0);
    access(1, 0, 8'h00, 8'h00, rd, st);
    check_eq("mix00_stalls", st, 0);
    access(1, 0, 8'h20, 8'h00, rd, st);
    check_eq("mix20_stalls", st, 5);
    check_eq("mix20_data", {24'b0, rd}, 32'h55);
    check_eq("mix_nlog", n_log, 6);
    log_check("mix_fetch00", 4, 1'b0, 6'h00, 32'h0, 1'b0);
    log_check("mix_fetch20", 5, 1'b0, 6'h08, 32'h0, 1'b0);
    access(1, 0, 8'h00, 8'h00, rd, st);
    check_eq("mix00b_stalls", st, 0);
    check_eq("mix00b_data", {24'b0, rd}, 32'hAA);
    check_eq("mix_hits", {16'b0, hit_count}, 7);
    check_eq("mix_misses", {16'b0, miss_count}, 5);

    // read and write together: no stall, no state or counter change.
    access(1, 1, 8'h02, 8'hFF, rd, st);
    check_eq("rw_stalls", st, 0);
    check_eq("rw_hits", {16'b0, hit_count}, 7);
    check_eq("rw_misses", {16'b0, miss_count}, 5);
    access(1, 0, 8'h02, 8'h00, rd, st);
    check_eq("rw_data_kept", {24'b0, rd}, 32'hCC);
    check_eq("sat_hits", {30'b0, hit_count2}, 3);
    check_eq("sat_misses", {30'b0, miss_count2}, 3);
    check_eq("overlap", n_overlap, 0);

    // Reset during a stalled fetch.
    mem_lat = 1000;
    @(negedge clock);
    read = 1'b1; write = 1'b0; address = 8'h04;
    repeat (3) @(negedge clock);
    #1;
    check_eq("fetch_pending", {31'b0, mem_read}, 1);
    #1 reset = 1'b1;
    #1;
    check_eq("abort_mem_read", {31'b0, mem_read}, 0);
    check_eq("abort_busywait", {31'b0, busywait}, 0);
    check_eq("abort_mem_write", {31'b0, mem_write}, 0);
    @(negedge clock);
    read = 1'b0;
    reset = 1'b0;
    mem_lat = 2;
    access(1, 0, 8'h00, 8'h00, rd, st);
    check_eq("post_rst_stalls", st, 5);
    check_eq("post_rst_data", {24'b0, rd}, 32'hAA);
    check_eq("post_rst_misses", {16'b0, miss_count}, 1);
    check_eq("post_rst_hits", {16'b0, hit_count}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
